snake_engine: RTL and testbench

- Parametrised game core for the LED-matrix snake game.
- Holds the snake body as a ring buffer of coordinates plus an occupancy bitmap.
- Advances one cell per move tick, grows on food, and detects wall and self collisions, entering a latched game-over state.
- Sits between the move-tick divider, the food generator and the row-scan display driver; the scan driver reads the bitmap one row at a time.

---
 rtl/snake_pkg.sv | 35 +++
 rtl/snake_body_fifo.sv | 69 ++++++
 rtl/snake_engine.sv | 181 ++++++++++++++++++
 tb/tb_snake_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg: shared heading/state encodings for the snake game core.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package snake_pkg;

    typedef enum logic [1:0] {
        LEFT  = 2'b00,
        DOWN  = 2'b01,
        UP    = 2'b10,
        RIGHT = 2'b11
    } heading_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        CALC   = 2'b01,
        COMMIT = 2'b10,
        OVER   = 2'b11
    } state_t;

    localparam int unsigned DIR_LEFT  = 0;
    localparam int unsigned DIR_DOWN  = 1;
    localparam int unsigned DIR_UP    = 2;
    localparam int unsigned DIR_RIGHT = 3;

    // The encoding makes every heading the bitwise complement of its reverse.
    function automatic heading_t opposite(heading_t h);
        return heading_t'(~h);
    endfunction

endpackage

`default_nettype wire

// File: rtl/snake_body_fifo.sv
// ---------------------------------------------------------------------------
// snake_body_fifo: ring buffer of body coordinates, head pushed, tail popped.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module snake_body_fifo #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int XW       = 3,
    parameter int YW       = 3
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          init_i,
    input  logic          push_i,
    input  logic [XW-1:0] push_x_i,
    input  logic [YW-1:0] push_y_i,
    input  logic          pop_i,
    output logic [XW-1:0] tail_x_o,
    output logic [YW-1:0] tail_y_o
);

    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [PW-1:0] c_LAST    = PW'(MAX_LEN - 1);
    localparam logic [PW-1:0] c_WR_INIT = PW'(INIT_LEN % MAX_LEN);

    logic [XW-1:0] mem_x_q [MAX_LEN];
    logic [YW-1:0] mem_y_q [MAX_LEN];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;

    function automatic logic [PW-1:0] next_ptr(logic [PW-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                mem_x_q[i] <= (i < INIT_LEN) ? XW'(i) : '0;
                mem_y_q[i] <= '0;
            end
            wr_q <= c_WR_INIT;
            rd_q <= '0;
        end else if (init_i) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                mem_x_q[i] <= (i < INIT_LEN) ? XW'(i) : '0;
                mem_y_q[i] <= '0;
            end
            wr_q <= c_WR_INIT;
            rd_q <= '0;
        end else begin
            if (push_i) begin
                mem_x_q[wr_q] <= push_x_i;
                mem_y_q[wr_q] <= push_y_i;
                wr_q          <= next_ptr(wr_q);
            end
            if (pop_i) begin
                rd_q <= next_ptr(rd_q);
            end
        end
    end

    assign tail_x_o = mem_x_q[rd_q];
    assign tail_y_o = mem_y_q[rd_q];

endmodule

`default_nettype wire

// File: rtl/snake_engine.sv
// ---------------------------------------------------------------------------
// snake_engine: snake game core (movement, growth, collisions, bitmap readout).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module snake_engine
    import snake_pkg::*;
#(
    parameter  int GRID_W   = 8,
    parameter  int GRID_H   = 8,
    parameter  int MAX_LEN  = 16,
    parameter  int INIT_LEN = 3,
    parameter  int WRAP     = 0,
    localparam int XW       = $clog2(GRID_W),
    localparam int YW       = $clog2(GRID_H),
    localparam int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              step,
    input  logic [3:0]        direction,
    input  logic              restart,
    input  logic              food_valid,
    input  logic [XW-1:0]     food_x,
    input  logic [YW-1:0]     food_y,
    output logic              food_eaten,
    output logic              game_over,
    output logic [LW-1:0]     length,
    output logic [XW-1:0]     head_x,
    output logic [YW-1:0]     head_y,
    input  logic [YW-1:0]     rd_row,
    output logic [GRID_W-1:0] rd_data
);

    localparam logic [XW-1:0]     c_XMAX     = XW'(GRID_W - 1);
    localparam logic [YW-1:0]     c_YMAX     = YW'(GRID_H - 1);
    localparam logic [LW-1:0]     c_MAX_LEN  = LW'(MAX_LEN);
    localparam logic [LW-1:0]     c_INIT_LEN = LW'(INIT_LEN);
    localparam logic [XW-1:0]     c_HEAD_X0  = XW'(INIT_LEN - 1);
    localparam logic [GRID_W-1:0] c_ROW0     = GRID_W'((64'd1 << INIT_LEN) - 64'd1);
    localparam logic              c_EDGE_DIE = (WRAP == 0);

    state_t              state_q;
    heading_t            heading_q, pending_q, req_d;
    logic                req_valid_d;
    logic [XW-1:0]       head_x_q, nx_d, nx_q, tail_x;
    logic [YW-1:0]       head_y_q, ny_d, ny_q, tail_y;
    logic [LW-1:0]       length_q;
    logic                game_over_q, food_eaten_q;
    logic [GRID_W-1:0]   rd_data_q;
    logic [GRID_W-1:0]   bitmap_q [GRID_H];
    logic                oob_d, eat_d, grow_d, hit_d;
    logic                oob_q, eat_q, grow_q, hit_q;
    logic                push, pop;

    always_comb begin
        req_valid_d = 1'b1;
        req_d       = RIGHT;
        if (direction[DIR_RIGHT])     req_d = RIGHT;
        else if (direction[DIR_LEFT]) req_d = LEFT;
        else if (direction[DIR_DOWN]) req_d = DOWN;
        else if (direction[DIR_UP])   req_d = UP;
        else                          req_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)                                            pending_q <= RIGHT;
        else if (restart)                                        pending_q <= RIGHT;
        else if (req_valid_d && req_d != opposite(heading_q))    pending_q <= req_d;
    end

    // Next-head candidate uses the pending heading, which CALC commits.
    always_comb begin
        nx_d  = head_x_q;
        ny_d  = head_y_q;
        oob_d = 1'b0;
        case (pending_q)
            RIGHT: if (head_x_q == c_XMAX) begin nx_d = '0;     oob_d = c_EDGE_DIE; end
                   else nx_d = head_x_q + 1'b1;
            LEFT:  if (head_x_q == '0)     begin nx_d = c_XMAX; oob_d = c_EDGE_DIE; end
                   else nx_d = head_x_q - 1'b1;
            DOWN:  if (head_y_q == c_YMAX) begin ny_d = '0;     oob_d = c_EDGE_DIE; end
                   else ny_d = head_y_q + 1'b1;
            default: if (head_y_q == '0)   begin ny_d = c_YMAX; oob_d = c_EDGE_DIE; end
                   else ny_d = head_y_q - 1'b1;
        endcase
        eat_d  = food_valid && (nx_d == food_x) && (ny_d == food_y);
        grow_d = eat_d && (length_q < c_MAX_LEN);
        // The tail cell is vacated in the same move unless the snake grows.
        hit_d  = !oob_d && bitmap_q[ny_d][nx_d] &&
                 !(!grow_d && nx_d == tail_x && ny_d == tail_y);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= RUN;
            heading_q    <= RIGHT;
            head_x_q     <= c_HEAD_X0;
            head_y_q     <= '0;
            length_q     <= c_INIT_LEN;
            game_over_q  <= 1'b0;
            food_eaten_q <= 1'b0;
            rd_data_q    <= '0;
            {nx_q, ny_q, oob_q, eat_q, grow_q, hit_q} <= '0;
            for (int r = 0; r < GRID_H; r++) bitmap_q[r] <= (r == 0) ? c_ROW0 : '0;
        end else if (restart) begin
            state_q      <= RUN;
            heading_q    <= RIGHT;
            head_x_q     <= c_HEAD_X0;
            head_y_q     <= '0;
            length_q     <= c_INIT_LEN;
            game_over_q  <= 1'b0;
            food_eaten_q <= 1'b0;
            rd_data_q    <= '0;
            {nx_q, ny_q, oob_q, eat_q, grow_q, hit_q} <= '0;
            for (int r = 0; r < GRID_H; r++) bitmap_q[r] <= (r == 0) ? c_ROW0 : '0;
        end else begin
            food_eaten_q <= 1'b0;
            rd_data_q    <= (rd_row <= c_YMAX) ? bitmap_q[rd_row] : '0;
            case (state_q)
                RUN: if (step) state_q <= CALC;
                CALC: begin
                    heading_q <= pending_q;
                    nx_q      <= nx_d;
                    ny_q      <= ny_d;
                    oob_q     <= oob_d;
                    eat_q     <= eat_d;
                    grow_q    <= grow_d;
                    hit_q     <= hit_d;
                    state_q   <= COMMIT;
                end
                COMMIT: begin
                    if (oob_q || hit_q) begin
                        game_over_q <= 1'b1;
                        state_q     <= OVER;
                    end else begin
                        if (!grow_q) bitmap_q[tail_y][tail_x] <= 1'b0;
                        bitmap_q[ny_q][nx_q] <= 1'b1;
                        head_x_q     <= nx_q;
                        head_y_q     <= ny_q;
                        if (grow_q) length_q <= length_q + 1'b1;
                        food_eaten_q <= eat_q;
                        state_q      <= RUN;
                    end
                end
                default: state_q <= OVER;
            endcase
        end
    end

    assign push = (state_q == COMMIT) && !restart && !(oob_q || hit_q);
    assign pop  = push && !grow_q;

    snake_body_fifo #(
        .MAX_LEN  (MAX_LEN),
        .INIT_LEN (INIT_LEN),
        .XW       (XW),
        .YW       (YW)
    ) u_body (
        .clk      (clk),
        .clear_n  (clear_n),
        .init_i   (restart),
        .push_i   (push),
        .push_x_i (nx_q),
        .push_y_i (ny_q),
        .pop_i    (pop),
        .tail_x_o (tail_x),
        .tail_y_o (tail_y)
    );

    assign food_eaten = food_eaten_q;
    assign game_over  = game_over_q;
    assign length     = length_q;
    assign head_x     = head_x_q;
    assign head_y     = head_y_q;
    assign rd_data    = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_snake_engine.sv
// ---------------------------------------------------------------------------
// tb_snake_engine: two engines (edge-kill, 16 deep / wrap, 6 deep) vs a list model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_snake_engine;

    logic       clk = 1'b0;
    logic       clear_n, step, restart, food_valid;
    logic [3:0] direction;
    logic [2:0] food_x, food_y, rd_row;

    logic       fe_a, go_a, fe_b, go_b;
    logic [4:0] len_a;
    logic [2:0] len_b;
    logic [2:0] hxa, hya, hxb, hyb;
    logic [7:0] rda, rdb;

    always #5 clk = ~clk;

    snake_engine #(.GRID_W(8), .GRID_H(8), .MAX_LEN(16), .INIT_LEN(3), .WRAP(0)) dut_a (
        .clk(clk), .clear_n(clear_n), .step(step), .direction(direction), .restart(restart),
        .food_valid(food_valid), .food_x(food_x), .food_y(food_y), .food_eaten(fe_a),
        .game_over(go_a), .length(len_a), .head_x(hxa), .head_y(hya),
        .rd_row(rd_row), .rd_data(rda));

    snake_engine #(.GRID_W(8), .GRID_H(8), .MAX_LEN(6), .INIT_LEN(3), .WRAP(1)) dut_b (
        .clk(clk), .clear_n(clear_n), .step(step), .direction(direction), .restart(restart),
        .food_valid(food_valid), .food_x(food_x), .food_y(food_y), .food_eaten(fe_b),
        .game_over(go_b), .length(len_b), .head_x(hxb), .head_y(hyb),
        .rd_row(rd_row), .rd_data(rdb));

    // Model: body as a list of cells, index 0 = tail; headings 0=L 1=D 2=U 3=R.
    int bx[2][16], by[2][16], blen[2], hd[2], pend[2], ovr[2], eexp[2];
    int wrapv[2] = '{0, 1};
    int maxl[2]  = '{16, 6};
    int rowobs[2][8];
    int passes = 0, total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] o_hx(int k);  return (k == 0) ? 32'(hxa) : 32'(hxb); endfunction
    function automatic logic [31:0] o_hy(int k);  return (k == 0) ? 32'(hya) : 32'(hyb); endfunction
    function automatic logic [31:0] o_len(int k); return (k == 0) ? 32'(len_a) : 32'(len_b); endfunction
    function automatic logic [31:0] o_go(int k);  return (k == 0) ? 32'(go_a) : 32'(go_b); endfunction
    function automatic logic [31:0] o_fe(int k);  return (k == 0) ? 32'(fe_a) : 32'(fe_b); endfunction
    function automatic logic [31:0] o_rd(int k);  return (k == 0) ? 32'(rda) : 32'(rdb); endfunction

    function automatic int exp_row(int k, int r);
        int v = 0;
        for (int i = 0; i < blen[k]; i++) if (by[k][i] == r) v |= (1 << bx[k][i]);
        return v;
    endfunction

    task automatic model_init();
        for (int k = 0; k < 2; k++) begin
            blen[k] = 3; hd[k] = 3; pend[k] = 3; ovr[k] = 0; eexp[k] = 0;
            for (int i = 0; i < 3; i++) begin bx[k][i] = i; by[k][i] = 0; end
        end
    endtask

    task automatic model_move(int k);
        int nx, ny, oob, eat, grow, hit;
        eexp[k] = 0;
        if (ovr[k] == 0) begin
            hd[k] = pend[k];
            nx = bx[k][blen[k]-1];
            ny = by[k][blen[k]-1];
            case (hd[k])
                0: nx--;
                1: ny++;
                2: ny--;
                default: nx++;
            endcase
            oob = (nx < 0 || nx > 7 || ny < 0 || ny > 7) ? 1 : 0;
            if (wrapv[k] == 1) begin nx = (nx + 8) % 8; ny = (ny + 8) % 8; oob = 0; end
            eat  = (food_valid && nx == int'(food_x) && ny == int'(food_y)) ? 1 : 0;
            grow = (eat == 1 && blen[k] < maxl[k]) ? 1 : 0;
            hit  = 0;
            if (oob == 0)
                for (int i = (grow == 1) ? 0 : 1; i < blen[k]; i++)
                    if (bx[k][i] == nx && by[k][i] == ny) hit = 1;
            if (oob == 1 || hit == 1) begin
                ovr[k] = 1;
            end else begin
                if (grow == 0) begin
                    for (int i = 0; i < blen[k] - 1; i++) begin
                        bx[k][i] = bx[k][i+1]; by[k][i] = by[k][i+1];
                    end
                    blen[k]--;
                end
                bx[k][blen[k]] = nx; by[k][blen[k]] = ny; blen[k]++;
                eexp[k] = eat;
            end
        end
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_hx%0d", tag, k), o_hx(k), 32'(bx[k][blen[k]-1]));
            chk($sformatf("%s_hy%0d", tag, k), o_hy(k), 32'(by[k][blen[k]-1]));
            chk($sformatf("%s_len%0d", tag, k), o_len(k), 32'(blen[k]));
            chk($sformatf("%s_go%0d", tag, k), o_go(k), 32'(ovr[k]));
        end
    endtask

    task automatic check_rows(input string tag);
        for (int r = 0; r < 8; r++) begin
            @(negedge clk) rd_row = 3'(r);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                rowobs[k][r] = int'(o_rd(k));
                chk($sformatf("%s_row%0d_%0d", tag, r, k), o_rd(k), 32'(exp_row(k, r)));
            end
        end
    endtask

    task automatic press(input logic [3:0] d);
        int req;
        @(negedge clk) direction = d;
        if (d != 4'b0) begin
            req = d[3] ? 3 : d[0] ? 0 : d[1] ? 1 : 2;
            for (int k = 0; k < 2; k++) if (req != 3 - hd[k]) pend[k] = req;
        end
        @(negedge clk) direction = 4'b0;
    endtask

    // Step in cycle N; food_eaten may only be high in cycle N+3.
    task automatic do_step(input string tag);
        for (int k = 0; k < 2; k++) model_move(k);
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk($sformatf("%s_fe_early%0d", tag, k), o_fe(k), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk($sformatf("%s_fe%0d", tag, k), o_fe(k), 32'(eexp[k]));
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk($sformatf("%s_fe_late%0d", tag, k), o_fe(k), 32'd0);
        check_state(tag);
    endtask

    task automatic do_restart(input string tag);
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
        model_init();
        check_state(tag);
    endtask

    task automatic abort_move(input int delay, input string tag);
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
        repeat (delay) @(negedge clk);
        restart = 1'b1;
        @(negedge clk) restart = 1'b0;
        model_init();
        repeat (3) @(negedge clk);
        check_state(tag);
        check_rows(tag);
    endtask

    initial begin
        int d;
        clear_n = 1'b0; step = 1'b0; restart = 1'b0; food_valid = 1'b0;
        direction = 4'b0; food_x = 3'd0; food_y = 3'd0; rd_row = 3'd0;
        model_init();
        repeat (3) @(negedge clk);
        check_state("reset");
        chk("reset_rd_a", 32'(rda), 32'd0);
        chk("reset_rd_b", 32'(rdb), 32'd0);
        clear_n = 1'b1;
        check_rows("init");
        chk("init_row0_a", 32'(rowobs[0][0]), 32'h07);

        repeat (5) do_step("right");
        check_rows("right5");
        chk("right5_hx_a", 32'(hxa), 32'd7);
        chk("right5_row0_a", 32'(rowobs[0][0]), 32'hE0);
        do_step("wall");
        chk("wall_go_a", 32'(go_a), 32'd1);
        check_rows("wall");
        chk("wall_row0_a", 32'(rowobs[0][0]), 32'hE0);
        chk("wrap_hx_b", 32'(hxb), 32'd0);
        chk("wrap_row0_b", 32'(rowobs[1][0]), 32'hC1);
        do_step("ignored");

        do_restart("rst1");
        press(4'b0010);
        do_step("down");
        check_rows("down");
        chk("down_row0_a", 32'(rowobs[0][0]), 32'h06);
        chk("down_row1_a", 32'(rowobs[0][1]), 32'h04);
        press(4'b0100);
        do_step("reverse");
        chk("reverse_hy_a", 32'(hya), 32'd2);

        do_restart("rst2");
        food_valid = 1'b1; food_x = 3'd3; food_y = 3'd0;
        do_step("eat");
        chk("eat_len_a", 32'(len_a), 32'd4);
        check_rows("eat");
        chk("eat_row0_a", 32'(rowobs[0][0]), 32'h0F);
        for (int i = 0; i < 6; i++) begin
            food_x = 3'((bx[1][blen[1]-1] + 1) % 8);
            do_step("feed");
        end
        chk("sat_len_b", 32'(len_b), 32'd6);
        food_valid = 1'b0;

        do_restart("rst3");
        food_valid = 1'b1; food_x = 3'd3; food_y = 3'd0;
        do_step("grow1");
        food_x = 3'd4;
        do_step("grow2");
        food_valid = 1'b0;
        press(4'b0010); do_step("coil_d");
        press(4'b0001); do_step("coil_l");
        food_valid = 1'b1; food_x = 3'd3; food_y = 3'd0;
        press(4'b0100); do_step("bite");
        chk("bite_go_a", 32'(go_a), 32'd1);
        chk("bite_go_b", 32'(go_b), 32'd1);
        check_rows("bite");
        food_valid = 1'b0;
        do_restart("rst4");
        check_rows("rst4");
        chk("rst4_row0_a", 32'(rowobs[0][0]), 32'h07);

        abort_move(0, "abort_calc");
        abort_move(1, "abort_commit");

        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 19) == 0 || (ovr[0] == 1 && ovr[1] == 1)) do_restart("rnd_rst");
            repeat ($urandom_range(0, 2)) press(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) begin
                d = int'($urandom_range(0, 3));
                food_valid = 1'b1;
                food_x = 3'((bx[0][blen[0]-1] + ((d == 0) ? 7 : (d == 3) ? 1 : 0)) % 8);
                food_y = 3'((by[0][blen[0]-1] + ((d == 2) ? 7 : (d == 1) ? 1 : 0)) % 8);
            end else begin
                food_valid = 1'($urandom_range(0, 1));
                food_x = 3'($urandom_range(0, 7));
                food_y = 3'($urandom_range(0, 7));
            end
            do_step("rnd");
            if (it % 15 == 14) check_rows("rnd");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire
